fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the nano RV32I core: owns the program counter, issues word requests to instruction memory over a req/ack handshake and buffers returned instructions for decode. It consumes the branch decision produced by the execute-stage compare logic: a taken branch redirects the PC, kills any in-flight fetch and flushes buffered instructions. Sits between instruction memory and decode.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- take_branch_i  in  1  redirect request from branch compare
- branch_target_i  in  32  redirect address
- stall_i  in  1  decode not accepting this cycle
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch word address
- imem_ack_i  in  1  request completed; imem_rdata_i valid this cycle
- imem_rdata_i  in  32  instruction word
- instr_valid_o  out  1  instr_o/instr_pc_o valid
- instr_o  out  32  instruction to decode
- instr_pc_o  out  32  PC of instr_o
- misaligned_o  out  1  sticky misaligned-redirect flag (0 when feature compiled out)

## Operation
- States: IDLE, FETCH, KILL, HALT. Reset -> IDLE; IDLE -> FETCH unconditionally.
- FETCH: imem_req_o = 1 when buffer occupancy ≤ 1 (registered); once raised, req and addr held stable until imem_ack_i.
- Transfer = imem_req_o & imem_ack_i (ack may be same-cycle or N cycles later). On transfer without redirect: push {rdata, pc} into buffer, pc <= pc + 4 (mod 2^32, wraps).
- Buffer: 2 entries, FIFO; head drives instr_*; pop when instr_valid_o & !stall_i. Push and pop in same cycle allowed.
- Redirect (take_branch_i = 1), priority over stall and push: pc <= branch_target_i; buffer cleared; data of any same-cycle transfer discarded.
  - Request pending, no ack this cycle -> KILL: keep req/old addr until ack, discard data, then FETCH at new pc.
  - Otherwise stay FETCH; next request uses target.
- Redirect during KILL: pc updated, remain KILL.
- HALT: req 0, buffer empty; exit only by reset.

## Timing
- Reset values: imem_req_o 0, imem_addr_o RESET_PC, instr_valid_o 0, instr_o 0, instr_pc_o 0, misaligned_o 0, state IDLE, occupancy 0.
- req first high in 2nd cycle after reset release (IDLE occupies 1 cycle).
- Transfer in cycle N -> instr_valid_o in N+1 (if buffer was empty).
- Zero-wait memory, no stall: one instruction per cycle.
- Redirect in cycle N -> instr_valid_o 0 in N+1; earliest target request N+1 (no pending fetch).
- Reset mid-request: all state cleared immediately; pending ack ignored after reset.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with branch_target_i[1:0] ≠ 0 sets misaligned_o (sticky), clears buffer, enters HALT (waits in KILL first if a request is pending, then HALT).
- Undefined: branch_target_i[1:0] forced to 2'b00; misaligned_o tied 0; HALT unreachable.

## Structure
- Package fetch_pkg: state encoding (IDLE/FETCH/KILL/HALT), XLEN = 32, PC_STEP = 4, default RESET_PC.
- Sub-module fetch_skid_buf: 2-entry instr/pc FIFO with push, pop, flush, occupancy output.

## Test plan
- Reset release, zero-wait memory returning addr as data -> req in cycle 2 at 0x0, instr_pc_o 0x0,0x4,0x8 in consecutive cycles.
- stall_i held 5 cycles -> occupancy reaches 2, req drops, no instruction lost or duplicated; release resumes in order.
- Ack delayed 3 cycles, take_branch_i with target 0x100 in cycle 1 of wait -> addr held until ack, data discarded, next req addr 0x100, first delivered pc 0x100.
- take_branch_i same cycle as ack at 0x8 -> word at 0x8 discarded, buffer flushed, next pc 0x40 (target).
- Macro defined, target 0x102 -> misaligned_o 1, req stays 0 forever; macro undefined -> next req addr 0x100.
- rst_i asserted while req pending -> outputs return to reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the nano RV32I instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;
    localparam word_t ALIGN_MASK       = 32'h0000_0003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        KILL  = 2'd2,
        HALT  = 2'd3
    } state_t;

    function automatic word_t next_pc(input word_t pc);
        return pc + word_t'(PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry instruction/PC FIFO between the fetch handshake and decode.
// Flush wins over push and pop in the same cycle.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  word_t       push_instr_i,
    input  word_t       push_pc_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic        valid_o,
    output word_t       instr_o,
    output word_t       pc_o,
    output logic [1:0]  count_o
);

    word_t      instr_q [2];
    word_t      instr_d [2];
    word_t      pc_q    [2];
    word_t      pc_d    [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    // NOTE: every variable gets its default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                instr_d[wr_ptr_q] = push_instr_i;
                pc_d[wr_ptr_q]    = push_pc_i;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: the two entries are reset as well so instr_o/instr_pc_o read 0 out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign instr_o = instr_q[rd_ptr_q];
    assign pc_o    = pc_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, 2-deep decode buffer, branch redirect.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets into HALT.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        take_branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        misaligned_o
);

    state_t     state_q, state_d;
    word_t      pc_q, pc_d;
    word_t      addr_q, addr_d;
    logic       req_q, req_d;
    logic       mis_q, mis_d;

    logic       transfer;
    logic       pending;
    logic       bad_target;
    word_t      target;
    logic       push;
    logic       pop;
    logic       flush;
    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic       buf_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target     = branch_target_i;
    assign bad_target = take_branch_i & ((branch_target_i & ALIGN_MASK) != '0);
`else
    assign target     = branch_target_i & ~ALIGN_MASK;
    assign bad_target = 1'b0;
`endif

    assign transfer = req_q & imem_ack_i;
    assign pending  = req_q & ~imem_ack_i;
    assign pop      = buf_valid & ~stall_i & ~flush;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = mis_q;
        push    = 1'b0;
        flush   = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (take_branch_i) begin
                    pc_d  = target;
                    flush = 1'b1;
                    mis_d = mis_q | bad_target;
                    // An unacked request must complete before the new stream starts.
                    if (pending)         state_d = KILL;
                    else if (bad_target) state_d = HALT;
                end else if (transfer) begin
                    push = 1'b1;
                    pc_d = next_pc(pc_q);
                end
            end
            KILL: begin
                if (take_branch_i) begin
                    pc_d  = target;
                    mis_d = mis_q | bad_target;
                end
                if (transfer) state_d = mis_d ? HALT : FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Raising req only when next occupancy is <= 1 guarantees a free slot whenever ack arrives.
    always_comb begin
        if (pending) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = (state_d == FETCH) && (occ_d <= 2'd1);
            addr_d = pc_d;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            mis_q   <= mis_d;
        end
    end

    fetch_skid_buf u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_instr_i (imem_rdata_i),
        .push_pc_i    (addr_q),
        .pop_i        (pop),
        .flush_i      (flush),
        .valid_o      (buf_valid),
        .instr_o      (instr_o),
        .pc_o         (instr_pc_o),
        .count_o      (occ_q)
    );

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = buf_valid;
    assign misaligned_o  = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model returns the address as data, a monitor
// compares every instruction decode consumes against the queue of expected PCs.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        take_branch_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        stall_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        misaligned_o;

    int n_checks = 0;
    int n_pass   = 0;
    int mem_budget = 0;
    int mem_delay  = 0;
    int mem_cnt    = 0;
    logic [31:0] exp_q[$];

    fetch_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .take_branch_i   (take_branch_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .misaligned_o    (misaligned_o)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Memory model: acks after mem_delay waiting cycles, while budget remains; data = address.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            imem_ack_i = 1'b0;
            mem_cnt    = 0;
        end else if (imem_req_o && mem_budget > 0) begin
            if (mem_cnt >= mem_delay) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = imem_addr_o;
                mem_budget--;
                mem_cnt      = 0;
            end else begin
                imem_ack_i = 1'b0;
                mem_cnt++;
            end
        end else begin
            imem_ack_i = 1'b0;
            mem_cnt    = 0;
        end
    end

    // Monitor: an instruction is consumed when valid, not stalled and not flushed by a redirect.
    initial forever begin
        logic [31:0] e;
        @(negedge clk_i);
        if (!rst_i && instr_valid_o && !stall_i && !take_branch_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got pc 0x%08h expected none", instr_pc_o);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc_o, e);
                check("instr_data", instr_o, e);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Holds reset two cycles and releases it; returns in cycle 1 after release (IDLE).
    task automatic apply_reset(input int budget, input int delay);
        rst_i           = 1'b1;
        take_branch_i   = 1'b0;
        branch_target_i = '0;
        stall_i         = 1'b0;
        mem_budget      = budget;
        mem_delay       = delay;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(posedge clk_i);
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge clk_i);
    endtask

    initial begin
        int seen;

        // 1: reset values, first request in cycle 2, back-to-back delivery
        #1;
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_instr_pc", instr_pc_o, 32'h0);
        check("rst_misaligned", {31'd0, misaligned_o}, 32'd0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        apply_reset(3, 0);
        check("t1_c1_req", {31'd0, imem_req_o}, 32'd0);
        next_cycle();
        check("t1_c2_req", {31'd0, imem_req_o}, 32'd1);
        check("t1_c2_addr", imem_addr_o, 32'h0);
        next_cycle();
        check("t1_c3_valid", {31'd0, instr_valid_o}, 32'd1);
        check("t1_c3_pc", instr_pc_o, 32'h0);
        next_cycle();
        check("t1_c4_pc", instr_pc_o, 32'h4);
        next_cycle();
        check("t1_c5_pc", instr_pc_o, 32'h8);
        drain("t1_drain");

        // 2: stall fills the buffer, request drops, release resumes in order
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        apply_reset(6, 0);
        stall_i = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        check("t2_full_req", {31'd0, imem_req_o}, 32'd0);
        check("t2_full_valid", {31'd0, instr_valid_o}, 32'd1);
        check("t2_full_pc", instr_pc_o, 32'h0);
        next_cycle();
        check("t2_hold_req", {31'd0, imem_req_o}, 32'd0);
        next_cycle();
        stall_i = 1'b0;
        drain("t2_drain");

        // 3: redirect while a slow fetch is outstanding
        exp_q.push_back(32'h100);
        apply_reset(2, 3);
        next_cycle();
        check("t3_req", {31'd0, imem_req_o}, 32'd1);
        take_branch_i   = 1'b1;
        branch_target_i = 32'h100;
        next_cycle();
        take_branch_i = 1'b0;
        check("t3_kill_req", {31'd0, imem_req_o}, 32'd1);
        check("t3_kill_addr", imem_addr_o, 32'h0);
        check("t3_kill_valid", {31'd0, instr_valid_o}, 32'd0);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            next_cycle();
            if (imem_req_o && imem_addr_o != 32'h0) seen = 1;
        end
        check("t3_new_addr", imem_addr_o, 32'h100);
        drain("t3_drain");

        // 4: redirect in the same cycle as the ack at 0x8
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        apply_reset(5, 0);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            next_cycle();
            if (imem_req_o && imem_addr_o == 32'h8) seen = 1;
        end
        check("t4_at_8", imem_addr_o, 32'h8);
        take_branch_i   = 1'b1;
        branch_target_i = 32'h40;
        next_cycle();
        take_branch_i = 1'b0;
        check("t4_flush_valid", {31'd0, instr_valid_o}, 32'd0);
        check("t4_tgt_req", {31'd0, imem_req_o}, 32'd1);
        check("t4_tgt_addr", imem_addr_o, 32'h40);
        drain("t4_drain");

        // 5: misaligned redirect target
        apply_reset(1, 0);
        next_cycle();
        take_branch_i   = 1'b1;
        branch_target_i = 32'h102;
        next_cycle();
        take_branch_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("t5_misaligned", {31'd0, misaligned_o}, 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_o) seen++;
            next_cycle();
        end
        check("t5_halt_req_count", 32'(seen), 32'd0);
        check("t5_halt_misaligned", {31'd0, misaligned_o}, 32'd1);
`else
        check("t5_misaligned", {31'd0, misaligned_o}, 32'd0);
        check("t5_req", {31'd0, imem_req_o}, 32'd1);
        check("t5_addr", imem_addr_o, 32'h100);
`endif
        drain("t5_drain");

        // 6: asynchronous reset with a request pending, then clean restart
        apply_reset(0, 0);
        next_cycle();
        check("t6_pending_req", {31'd0, imem_req_o}, 32'd1);
        next_cycle();
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_async_req", {31'd0, imem_req_o}, 32'd0);
        check("t6_async_addr", imem_addr_o, 32'h0);
        check("t6_async_valid", {31'd0, instr_valid_o}, 32'd0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        apply_reset(2, 0);
        check("t6_c1_req", {31'd0, imem_req_o}, 32'd0);
        next_cycle();
        check("t6_c2_req", {31'd0, imem_req_o}, 32'd1);
        check("t6_c2_addr", imem_addr_o, 32'h0);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
